sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 23 ++
 rtl/sram_controller_wait_counter.sv | 45 ++++
 rtl/sram_controller.sv | 147 ++++++++++++++
 tb/tb_sram_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
// Shared definitions for the SRAM controller slice:
//   - state_t        : controller FSM states (IDLE, ACCESS, DONE)
//   - *_DEF          : default WAIT_CYCLES / DATA_BASE parameter values
//   - SRAM_AW/SRAM_DW: SRAM word-address and data-bus widths
//   - CNT_W          : width of the access wait counter (covers 1..15)
// -----------------------------------------------------------------------------
package sram_controller_pkg;

   localparam int WAIT_CYCLES_DEF = 5;
   localparam int DATA_BASE_DEF   = 1024;
   localparam int SRAM_AW         = 17;
   localparam int SRAM_DW         = 32;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
// Down-counter that times the ACCESS phase of an SRAM transaction.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   value loaded on load
//   dec      in   decrement by one
//   zero     out  count is zero (combinational)
// -----------------------------------------------------------------------------
module sram_wait_counter
   import sram_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// MEM-stage SRAM controller. A load or store request in IDLE is latched and
// held on the SRAM pins for WAIT_CYCLES ACCESS cycles, followed by one DONE
// cycle in which ready is reasserted. The SRAM is organised as two 32-bit
// banks: DQ0 carries even words, DQ1 odd words; a read captures both.
// Ports:
//   CLK, RST     clock / synchronous active-high reset
//   wr_en, rd_en store / load request (store wins if both are set)
//   address      byte address; word = (address - DATA_BASE)[18:2]
//   write_data   store data
//   read_data    registered load word (selected by word address bit 0)
//   line_data    registered {odd word, even word} of the last read
//   ready        high when no transaction is pending (combinational)
//   SRAM_WE_N    active-low write enable
//   SRAM_ADDR    latched word address
//   SRAM_DQ0     even-word bus, driven only while a write is in ACCESS
//   SRAM_DQ1     odd-word bus, never driven here
// -----------------------------------------------------------------------------
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int DATA_BASE   = DATA_BASE_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic [63:0]        line_data,
   output logic               ready,
   output logic               SRAM_WE_N,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   inout  logic [SRAM_DW-1:0] SRAM_DQ0,
   inout  logic [SRAM_DW-1:0] SRAM_DQ1
);

   state_t               state_q, state_d;
   logic                 we_n_q, we_n_d;
   logic                 is_wr_q, is_wr_d;
   logic [SRAM_AW-1:0]   addr_q, addr_d;
   logic [SRAM_DW-1:0]   wdata_q, wdata_d;
   logic [31:0]          read_data_q, read_data_d;
   logic [63:0]          line_data_q, line_data_d;
   logic [SRAM_AW-1:0]   word_addr;
   logic                 req;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_zero;

   // Subtraction wraps modulo 2^32; the shift drops the byte offset and the
   // cast keeps bits [18:2].
   assign word_addr = SRAM_AW'((address - 32'(DATA_BASE)) >> 2);
   assign req       = wr_en | rd_en;

   // Loaded with WAIT_CYCLES-1 so that the zero flag marks the last ACCESS
   // cycle, giving exactly WAIT_CYCLES cycles in ACCESS.
   sram_wait_counter u_wait_counter (
      .clk      (CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val (CNT_W'(WAIT_CYCLES - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      we_n_d      = we_n_q;
      is_wr_d     = is_wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      line_data_d = line_data_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d  = ACCESS;
               is_wr_d  = wr_en;
               we_n_d   = ~wr_en;
               addr_d   = word_addr;
               wdata_d  = write_data;
               cnt_load = 1'b1;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d = DONE;
               we_n_d  = 1'b1;
               if (!is_wr_q) begin
                  line_data_d = {SRAM_DQ1, SRAM_DQ0};
                  read_data_d = addr_q[0] ? SRAM_DQ1 : SRAM_DQ0;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            // Always one cycle; a still-asserted request is taken in IDLE.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            we_n_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         we_n_q      <= 1'b1;
         is_wr_q     <= 1'b0;
         addr_q      <= '0;
         read_data_q <= '0;
         line_data_q <= '0;
      end else begin
         state_q     <= state_d;
         we_n_q      <= we_n_d;
         is_wr_q     <= is_wr_d;
         addr_q      <= addr_d;
         read_data_q <= read_data_d;
         line_data_q <= line_data_d;
      end
   end

   // Store data only matters while we_n_q is low, which reset forces high.
   always_ff @(posedge CLK) begin
      wdata_q <= wdata_d;
   end

   assign ready     = (state_q == DONE) || ((state_q == IDLE) && !req);
   assign SRAM_WE_N = we_n_q;
   assign SRAM_ADDR = addr_q;
   assign read_data = read_data_q;
   assign line_data = line_data_q;

   // we_n_q is low only during the ACCESS cycles of a write.
   assign SRAM_DQ0  = we_n_q ? {SRAM_DW{1'bz}} : wdata_q;
   assign SRAM_DQ1  = {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        mem_init;
   wire  [31:0] read_data;
   wire  [63:0] line_data;
   wire         ready;
   wire         sram_we_n;
   wire  [16:0] sram_addr;
   wire  [31:0] sram_dq0;
   wire  [31:0] sram_dq1;

   always #5 clk = ~clk;

   sram_controller dut (
      .CLK        (clk),
      .RST        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .line_data  (line_data),
      .ready      (ready),
      .SRAM_WE_N  (sram_we_n),
      .SRAM_ADDR  (sram_addr),
      .SRAM_DQ0   (sram_dq0),
      .SRAM_DQ1   (sram_dq1)
   );

   // Small SRAM model: low 6 address bits, even word on DQ0, odd word on DQ1,
   // writes take DQ0 into the addressed word.
   logic [31:0] mem [0:63];
   assign sram_dq0 = sram_we_n ? mem[{sram_addr[5:1], 1'b0}] : 32'bz;
   assign sram_dq1 = mem[{sram_addr[5:1], 1'b1}];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[2]  <= 32'h11111111;
         mem[3]  <= 32'h22222222;
         mem[5]  <= 32'h55AA55AA;
         mem[62] <= 32'h62626262;
         mem[63] <= 32'h63636363;
      end else if (!sram_we_n) begin
         mem[sram_addr[5:0]] <= sram_dq0;
      end
   end

   typedef struct {
      logic [31:0] rd;
      logic [63:0] line;
      int          lat;
      int          mem_idx;
      logic [31:0] mem_val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rd, input logic [63:0] line,
                               input int lat, input int idx, input logic [31:0] val);
      exp_t e;
      e.rd = rd; e.line = line; e.lat = lat; e.mem_idx = idx; e.mem_val = val;
      return e;
   endfunction

   // Monitor: a transaction ends when ready returns high after a low window.
   int   low_cnt = 0;
   bit   saw_rst = 1'b0;
   exp_t got;

   always @(negedge clk) begin
      if (rst) saw_rst = 1'b1;
      if (!ready) begin
         low_cnt++;
      end else begin
         if (low_cnt > 0 && !saw_rst) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_txn", 64'd1, 64'd0);
            end else begin
               got = sb_q.pop_front();
               check("sb_latency", 64'(low_cnt), 64'(got.lat));
               check("sb_read_data", 64'(read_data), 64'(got.rd));
               check("sb_line_data", line_data, got.line);
               if (got.mem_idx >= 0)
                  check("sb_mem_word", 64'(mem[got.mem_idx]), 64'(got.mem_val));
            end
         end
         low_cnt = 0;
         if (!rst) saw_rst = 1'b0;
      end
   end

   // Issue one request at posedge+1 and hold it until ready is seen (DONE).
   task automatic run_txn(input string nm, input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [16:0] exp_addr, input exp_t e, input bit hold);
      bit done = 1'b0;
      sb_q.push_back(e);
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) check({nm, "_ready_drop"}, 64'(ready), 64'd0);
         if (ready) begin
            done = 1'b1;
            break;
         end
         if (i > 0) begin
            check({nm, "_we_n"}, 64'(sram_we_n), 64'(!wr));
            check({nm, "_sram_addr"}, 64'(sram_addr), 64'(exp_addr));
            if (wr) check({nm, "_dq0"}, 64'(sram_dq0), 64'(d));
         end
      end
      if (!done) check({nm, "_timeout"}, 64'd0, 64'd1);
      @(posedge clk); #1;
      if (!hold) begin
         wr_en = 1'b0; rd_en = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      mem_init = 1'b1;
      repeat (2) @(posedge clk);
      #1 mem_init = 1'b0;
      @(negedge clk);
      check("rst_read_data", 64'(read_data), 64'd0);
      check("rst_line_data", line_data, 64'd0);
      check("rst_we_n", 64'(sram_we_n), 64'd1);
      check("rst_sram_addr", 64'(sram_addr), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 64'(ready), 64'd1);
      @(posedge clk); #1;

      run_txn("wr1028", 1, 0, 32'd1028, 32'hDEADBEEF, 17'd1,
              mk(32'h0, 64'h0, 6, 1, 32'hDEADBEEF), 0);
      run_txn("rd1036", 0, 1, 32'd1036, 32'h0, 17'd3,
              mk(32'h22222222, 64'h22222222_11111111, 6, -1, 32'h0), 0);
      run_txn("rd1032", 0, 1, 32'd1032, 32'h0, 17'd2,
              mk(32'h11111111, 64'h22222222_11111111, 6, -1, 32'h0), 0);
      run_txn("wrrd1024", 1, 1, 32'd1024, 32'd7, 17'd0,
              mk(32'h11111111, 64'h22222222_11111111, 6, 0, 32'd7), 0);
      run_txn("b2b_wr", 1, 0, 32'd1040, 32'hCAFEF00D, 17'd4,
              mk(32'h11111111, 64'h22222222_11111111, 6, 4, 32'hCAFEF00D), 1);
      run_txn("b2b_rd", 0, 1, 32'd1044, 32'h0, 17'd5,
              mk(32'h55AA55AA, 64'h55AA55AA_CAFEF00D, 6, -1, 32'h0), 0);
      run_txn("rd_wrap", 0, 1, 32'd1020, 32'h0, 17'h1FFFF,
              mk(32'h63636363, 64'h63636363_62626262, 6, -1, 32'h0), 0);

      // Reset during the 2nd ACCESS cycle of a write.
      wr_en = 1'b1; address = 32'd1048; write_data = 32'hBAD0BAD0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      check("abort_we_n_before", 64'(sram_we_n), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_we_n", 64'(sram_we_n), 64'd1);
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_sram_addr", 64'(sram_addr), 64'd0);
      check("abort_read_data", 64'(read_data), 64'd0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_ready", 64'(ready), 64'd1);
         check("idle_we_n", 64'(sram_we_n), 64'd1);
         check("idle_dq0", 64'(sram_dq0), 64'd7);
      end

      check("sb_leftover", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
